// File: rtl/acpu_mem_gen.sv
// acpu_mem_gen: audio CPU memory map and command mailbox.
// Decodes the 64 KiB audio CPU space into RAM, two YM selects, a mailbox and
// a download-loaded ROM. Main-to-audio commands are queued in a small FIFO
// that raises an IRQ while non-empty. Audio-to-main replies go through a
// single latch with a valid flag.
module acpu_mem_gen #(
  parameter int          ROM_AW  = 15,
  parameter int          RAM_AW  = 11,
  parameter logic [26:0] DL_BASE = 27'hc000,
  parameter int          FIFO_AW = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_cen,
  input  logic [15:0] acpu_ab,
  input  logic [7:0]  din,
  input  logic        rw,
  output logic [7:0]  dout,
  input  logic        ioctl_download,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic        ioctl_wr,
  input  logic [7:0]  mcpu_dout,
  input  logic        snd_write,
  input  logic        mcpu_rd_reply,
  output logic [7:0]  reply,
  output logic        reply_valid,
  output logic        acpu_irq_n,
  output logic        cs1,
  output logic        cs2,
  input  logic [7:0]  ym2203_data,
  input  logic [7:0]  ym3526_data
);

  localparam int             FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [27:0]    DL_END_C   = {1'b0, DL_BASE} + (28'd1 << ROM_AW);
  localparam logic [FIFO_AW:0]   CNT_ONE_C  = (FIFO_AW+1)'(1'b1);
  localparam logic [FIFO_AW:0]   CNT_ZERO_C = (FIFO_AW+1)'(1'b0);
  localparam logic [FIFO_AW-1:0] PTR_ONE_C  = FIFO_AW'(1'b1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO_C = FIFO_AW'(1'b0);

  typedef enum logic [2:0] {
    REG_RAM  = 3'd0,
    REG_CS1  = 3'd1,
    REG_CS2  = 3'd2,
    REG_MBOX = 3'd3,
    REG_ROM  = 3'd4
  } region_e;

  // Storage
  logic [7:0] ram_r  [0:(1<<RAM_AW)-1];
  logic [7:0] rom_r  [0:(1<<ROM_AW)-1];
  logic [7:0] fifo_r [0:FIFO_DEPTH-1];

  // Mailbox state
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [FIFO_AW:0]   count_nxt_s;
  logic               ovf_r;
  logic [7:0]         last_pop_r;
  logic               irq_n_r;
  logic [7:0]         dout_r;
  logic [7:0]         reply_r;
  logic               reply_valid_r;

  // Decode and strobes
  region_e     region_s;
  logic        mb_acc_s;
  logic        pop_s;
  logic        reply_wr_s;
  logic        ovf_clr_s;
  logic        ram_wr_s;
  logic        push_req_s;
  logic        push_ok_s;
  logic        ovf_set_s;
  logic        full_s;
  logic        nonempty_s;
  logic [7:0]  head_s;
  logic [7:0]  status_s;
  logic [7:0]  rd_data_s;
  logic [26:0] dl_off_s;
  logic        dl_hit_s;
  logic        unused_s;

  // Address decode: bit 15 picks the ROM, otherwise bits 14:13 pick the region.
  always_comb begin
    region_s = REG_RAM;
    if (acpu_ab[15]) begin
      region_s = REG_ROM;
    end else begin
      case (acpu_ab[14:13])
        2'd0:    region_s = REG_RAM;
        2'd1:    region_s = REG_CS1;
        2'd2:    region_s = REG_CS2;
        2'd3:    region_s = REG_MBOX;
        default: region_s = REG_RAM;
      endcase
    end
  end

  assign cs1 = (region_s == REG_CS1);
  assign cs2 = (region_s == REG_CS2);

  assign mb_acc_s   = cpu_cen && (region_s == REG_MBOX);
  assign full_s     = count_r[FIFO_AW];
  assign nonempty_s = (count_r != CNT_ZERO_C);
  assign pop_s      = mb_acc_s && rw && !acpu_ab[0] && nonempty_s && !ioctl_download;
  assign reply_wr_s = mb_acc_s && !rw && !acpu_ab[0];
  assign ovf_clr_s  = mb_acc_s && !rw && acpu_ab[0];
  assign ram_wr_s   = cpu_cen && !rw && (region_s == REG_RAM);
  assign push_req_s = snd_write && !ioctl_download;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign ovf_set_s  = push_req_s && full_s && !pop_s;

  assign head_s   = fifo_r[rd_ptr_r];
  assign status_s = {3'b000, 3'(count_r), ovf_r, nonempty_s};

  assign dl_off_s = ioctl_addr - DL_BASE;
  assign dl_hit_s = ioctl_download && ioctl_wr &&
                    ({1'b0, ioctl_addr} >= {1'b0, DL_BASE}) &&
                    ({1'b0, ioctl_addr} < DL_END_C);

  // Upper download data byte and high offset bits carry no information here.
  assign unused_s = ^{ioctl_dout[15:8], dl_off_s[26:ROM_AW]};

  // Next FIFO occupancy from the push/pop pair; download flushes it.
  always_comb begin
    count_nxt_s = count_r;
    if (ioctl_download) begin
      count_nxt_s = CNT_ZERO_C;
    end else if (push_ok_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE_C;
    end else if (pop_s && !push_ok_s) begin
      count_nxt_s = count_r - CNT_ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Read data mux for the audio CPU; mailbox offset 0 falls back to the last popped byte.
  always_comb begin
    rd_data_s = 8'h00;
    case (region_s)
      REG_RAM:  rd_data_s = ram_r[acpu_ab[RAM_AW-1:0]];
      REG_CS1:  rd_data_s = ym2203_data;
      REG_CS2:  rd_data_s = ym3526_data;
      REG_MBOX: begin
        if (acpu_ab[0]) begin
          rd_data_s = status_s;
        end else if (nonempty_s) begin
          rd_data_s = head_s;
        end else begin
          rd_data_s = last_pop_r;
        end
      end
      REG_ROM:  rd_data_s = rom_r[acpu_ab[ROM_AW-1:0]];
      default:  rd_data_s = 8'h00;
    endcase
  end

  // FIFO pointers, occupancy, sticky overflow, IRQ and last-popped byte.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_r   <= PTR_ZERO_C;
      rd_ptr_r   <= PTR_ZERO_C;
      count_r    <= CNT_ZERO_C;
      ovf_r      <= 1'b0;
      last_pop_r <= 8'h00;
      irq_n_r    <= 1'b1;
    end else if (ioctl_download) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
      ovf_r    <= 1'b0;
      irq_n_r  <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      irq_n_r <= (count_nxt_s == CNT_ZERO_C);
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE_C;
        last_pop_r <= head_s;
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk_sys) begin
    if (push_ok_s) begin
      fifo_r[wr_ptr_r] <= mcpu_dout;
    end
  end

  // Reply latch; an audio write beats a simultaneous consume strobe.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      reply_r       <= 8'h00;
      reply_valid_r <= 1'b0;
    end else begin
      if (reply_wr_s) begin
        reply_r <= din;
      end
      if (ioctl_download) begin
        reply_valid_r <= 1'b0;
      end else if (reply_wr_s) begin
        reply_valid_r <= 1'b1;
      end else if (mcpu_rd_reply) begin
        reply_valid_r <= 1'b0;
      end
    end
  end

  // Registered audio CPU read data, captured on each bus-cycle enable.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dout_r <= 8'h00;
    end else if (cpu_cen) begin
      dout_r <= rd_data_s;
    end
  end

  // Audio RAM write port; upper address bits in the region are mirrors.
  always_ff @(posedge clk_sys) begin
    if (ram_wr_s) begin
      ram_r[acpu_ab[RAM_AW-1:0]] <= din;
    end
  end

  // ROM write port, owned by the ioctl download.
  always_ff @(posedge clk_sys) begin
    if (dl_hit_s) begin
      rom_r[dl_off_s[ROM_AW-1:0]] <= ioctl_dout[7:0];
    end
  end

  assign dout        = dout_r;
  assign reply       = reply_r;
  assign reply_valid = reply_valid_r;
  assign acpu_irq_n  = irq_n_r;

endmodule

// File: tb/tb_acpu_mem_gen.sv
// Bench for acpu_mem_gen: directed scenarios with literal expectations, then
// randomized bus traffic, all checked every cycle against a queue-based model.
module tb_acpu_mem_gen;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpu_cen;
  logic [15:0] acpu_ab;
  logic [7:0]  din;
  logic        rw;
  logic [7:0]  dout;
  logic        ioctl_download;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic [7:0]  mcpu_dout;
  logic        snd_write;
  logic        mcpu_rd_reply;
  logic [7:0]  reply;
  logic        reply_valid;
  logic        acpu_irq_n;
  logic        cs1;
  logic        cs2;
  logic [7:0]  ym2203_data;
  logic [7:0]  ym3526_data;

  int tests = 0;
  int fails = 0;

  always #5 clk_sys = ~clk_sys;

  acpu_mem_gen dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_cen(cpu_cen), .acpu_ab(acpu_ab),
    .din(din), .rw(rw), .dout(dout), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .mcpu_dout(mcpu_dout), .snd_write(snd_write), .mcpu_rd_reply(mcpu_rd_reply),
    .reply(reply), .reply_valid(reply_valid), .acpu_irq_n(acpu_irq_n),
    .cs1(cs1), .cs2(cs2), .ym2203_data(ym2203_data), .ym3526_data(ym3526_data)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_rep = 8'h00;
  logic       m_rv = 1'b0;
  logic [7:0] m_dout = 8'h00;
  bit         m_dk = 1'b0;
  bit         armed = 1'b0;
  logic [7:0] m_ram [0:2047];
  bit         m_ram_k [0:2047];
  logic [7:0] m_rom [0:32767];
  bit         m_rom_k [0:32767];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_step();
    logic [7:0] rdv;
    bit         rdk;
    int         rg;
    int         off;
    logic       ne;
    if (!reset_n) begin
      m_q.delete();
      m_ovf = 1'b0; m_last = 8'h00; m_rep = 8'h00; m_rv = 1'b0;
      m_dout = 8'h00; m_dk = 1'b1; armed = 1'b1;
    end else begin
      rg  = acpu_ab[15] ? 4 : int'(acpu_ab[14:13]);
      rdk = 1'b1;
      rdv = 8'h00;
      ne  = (m_q.size() != 0);
      case (rg)
        0: begin rdv = m_ram[acpu_ab[10:0]]; rdk = m_ram_k[acpu_ab[10:0]]; end
        1: rdv = ym2203_data;
        2: rdv = ym3526_data;
        3: begin
          if (acpu_ab[0]) rdv = {3'b000, 3'(m_q.size()), m_ovf, ne};
          else if (ne)   rdv = m_q[0];
          else           rdv = m_last;
        end
        default: begin rdv = m_rom[acpu_ab[14:0]]; rdk = m_rom_k[acpu_ab[14:0]]; end
      endcase
      if (ioctl_download) begin
        off = int'(ioctl_addr) - 'hC000;
        if (ioctl_wr && off >= 0 && off < 32768) begin
          m_rom[off] = ioctl_dout[7:0];
          m_rom_k[off] = 1'b1;
        end
        m_q.delete();
        m_ovf = 1'b0;
        m_rv = 1'b0;
      end else begin
        if (cpu_cen && rw && rg == 3 && !acpu_ab[0] && ne) m_last = m_q.pop_front();
        if (cpu_cen && !rw && rg == 3 && acpu_ab[0]) m_ovf = 1'b0;
        if (snd_write) begin
          if (m_q.size() < 4) m_q.push_back(mcpu_dout);
          else m_ovf = 1'b1;
        end
        if (cpu_cen && !rw && rg == 3 && !acpu_ab[0]) begin
          m_rep = din; m_rv = 1'b1;
        end else if (mcpu_rd_reply) begin
          m_rv = 1'b0;
        end
      end
      if (cpu_cen && !rw && rg == 0) begin
        m_ram[acpu_ab[10:0]] = din;
        m_ram_k[acpu_ab[10:0]] = 1'b1;
      end
      if (cpu_cen) begin
        m_dout = rdv; m_dk = rdk;
      end
    end
  endtask

  task automatic m_compare();
    int rg;
    rg = acpu_ab[15] ? 4 : int'(acpu_ab[14:13]);
    if (m_dk) chk("m_dout", dout, m_dout);
    chk("m_reply", reply, m_rep);
    chk("m_reply_valid", {7'd0, reply_valid}, {7'd0, m_rv});
    chk("m_irq_n", {7'd0, acpu_irq_n}, {7'd0, m_q.size() == 0});
    chk("m_cs1", {7'd0, cs1}, {7'd0, rg == 1});
    chk("m_cs2", {7'd0, cs2}, {7'd0, rg == 2});
  endtask

  // Model advances on each edge with the inputs that edge saw, then is compared.
  always begin
    @(posedge clk_sys);
    m_step();
    #1;
    if (armed) m_compare();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic acc(input logic r, input logic [15:0] a, input logic [7:0] d);
    cpu_cen = 1'b1; rw = r; acpu_ab = a; din = d;
    tick();
    cpu_cen = 1'b0; rw = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    mcpu_dout = b; snd_write = 1'b1;
    tick();
    snd_write = 1'b0;
  endtask

  task automatic dl(input logic [26:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = {8'hE5, d}; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cpu_cen = 1'b0; acpu_ab = 16'h0000; din = 8'h00; rw = 1'b1;
    ioctl_download = 1'b0; ioctl_addr = 27'd0; ioctl_dout = 16'h0000; ioctl_wr = 1'b0;
    mcpu_dout = 8'h00; snd_write = 1'b0; mcpu_rd_reply = 1'b0;
    ym2203_data = 8'h00; ym3526_data = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_reply", reply, 8'h00);
    chk("rst_rv", {7'd0, reply_valid}, 8'h00);
    chk("rst_irq_n", {7'd0, acpu_irq_n}, 8'h01);

    // two pushes, status, two pops
    push(8'h11);
    chk("irq_after_push", {7'd0, acpu_irq_n}, 8'h00);
    push(8'h22);
    acc(1'b1, 16'h6001, 8'h00); chk("status_2", dout, 8'h09);
    acc(1'b1, 16'h6000, 8'h00); chk("pop_11", dout, 8'h11);
    acc(1'b1, 16'h6000, 8'h00); chk("pop_22", dout, 8'h22);
    chk("irq_empty", {7'd0, acpu_irq_n}, 8'h01);

    // overflow
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    acc(1'b1, 16'h6001, 8'h00); chk("status_ovf", dout, 8'h13);
    for (int i = 0; i < 4; i++) begin
      acc(1'b1, 16'h6000, 8'h00); chk("pop_A", dout, 8'hA0 + 8'(i));
    end
    acc(1'b1, 16'h6000, 8'h00); chk("pop_empty", dout, 8'hA3);
    acc(1'b0, 16'h6001, 8'h00);
    acc(1'b1, 16'h6001, 8'h00); chk("status_clr", dout, 8'h00);

    // full FIFO, push coincides with pop
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    mcpu_dout = 8'hB4; snd_write = 1'b1;
    acc(1'b1, 16'h6000, 8'h00);
    snd_write = 1'b0;
    chk("pop_B0_push", dout, 8'hB0);
    acc(1'b1, 16'h6001, 8'h00); chk("status_full_nov", dout, 8'h11);
    for (int i = 1; i < 5; i++) begin
      acc(1'b1, 16'h6000, 8'h00); chk("pop_B", dout, 8'hB0 + 8'(i));
    end

    // reply latch
    acc(1'b0, 16'h6000, 8'h5A);
    chk("reply_5A", reply, 8'h5A);
    chk("rv_set", {7'd0, reply_valid}, 8'h01);
    mcpu_rd_reply = 1'b1; tick(); mcpu_rd_reply = 1'b0;
    chk("rv_clr", {7'd0, reply_valid}, 8'h00);
    mcpu_rd_reply = 1'b1;
    acc(1'b0, 16'h6000, 8'h66);
    mcpu_rd_reply = 1'b0;
    chk("reply_66", reply, 8'h66);
    chk("rv_win", {7'd0, reply_valid}, 8'h01);

    // ROM download
    push(8'h31);
    ioctl_download = 1'b1;
    tick();
    dl(27'h000C000, 8'h3C);
    dl(27'h0014000, 8'h55);
    dl(27'h0013FFF, 8'h7E);
    dl(27'h000BFFF, 8'hAA);
    push(8'h77);
    ioctl_download = 1'b0;
    tick();
    chk("dl_irq_n", {7'd0, acpu_irq_n}, 8'h01);
    chk("dl_rv", {7'd0, reply_valid}, 8'h00);
    acc(1'b1, 16'h6001, 8'h00); chk("dl_status", dout, 8'h00);
    acc(1'b1, 16'h8000, 8'h00); chk("rom_8000", dout, 8'h3C);
    acc(1'b1, 16'hFFFF, 8'h00); chk("rom_FFFF", dout, 8'h7E);

    // RAM and YM selects
    acc(1'b0, 16'h0123, 8'h99);
    acc(1'b1, 16'h0123, 8'h00); chk("ram_0123", dout, 8'h99);
    acc(1'b1, 16'h0923, 8'h00); chk("ram_mirror", dout, 8'h99);
    ym2203_data = 8'hC1; ym3526_data = 8'hD2;
    acc(1'b1, 16'h2000, 8'h00);
    chk("ym2203", dout, 8'hC1);
    chk("cs1_on", {6'd0, cs1, cs2}, 8'h02);
    acc(1'b1, 16'h4000, 8'h00);
    chk("ym3526", dout, 8'hD2);
    chk("cs2_on", {6'd0, cs1, cs2}, 8'h01);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = int'($urandom_range(7, 0));
      cpu_cen = 1'($urandom_range(1, 0));
      rw = 1'($urandom_range(1, 0));
      din = 8'($urandom);
      case (k)
        0: acpu_ab = {3'b000, 2'($urandom), 6'd0, 5'($urandom)};
        1: acpu_ab = {3'b001, 13'($urandom)};
        2: acpu_ab = {3'b010, 13'($urandom)};
        3, 4, 5: acpu_ab = {3'b011, 12'($urandom), 1'b0};
        6: acpu_ab = {3'b011, 12'($urandom), 1'b1};
        default: begin
          acpu_ab = ($urandom_range(1, 0) == 0) ? 16'h8000 : 16'hFFFF;
          rw = 1'b1;
        end
      endcase
      snd_write = ($urandom_range(2, 0) == 0);
      mcpu_dout = 8'($urandom);
      mcpu_rd_reply = ($urandom_range(7, 0) == 0);
      ym2203_data = 8'($urandom);
      ym3526_data = 8'($urandom);
      tick();
    end
    cpu_cen = 1'b0; rw = 1'b1; snd_write = 1'b0; mcpu_rd_reply = 1'b0;

    // reset mid-transfer discards queued bytes
    acc(1'b1, 16'h6000, 8'h00);
    push(8'hE1); push(8'hE2); push(8'hE3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_irq_n", {7'd0, acpu_irq_n}, 8'h01);
    chk("mid_rst_dout", dout, 8'h00);
    acc(1'b1, 16'h6001, 8'h00); chk("mid_rst_status", dout, 8'h00);
    acc(1'b1, 16'h6000, 8'h00); chk("mid_rst_last", dout, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
